// File: rtl/lift_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lift_req_scheduler
// Description : Latches floor calls into a pending bitmap and picks the next
//               target floor for a single lift car using a SCAN policy.
//               Requests are retired when the door opens at their floor.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_req_scheduler #(
    parameter int NFLOORS = 5,
    parameter int FW      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] call_btn,
    input  logic [FW-1:0]      cur_floor,
    input  logic               door_open,
    output logic [FW-1:0]      req_floor,
    output logic               req_valid,
    output logic               dir_up,
    output logic [NFLOORS-1:0] pending,
    output logic               busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_move  = 2'd1;
    localparam logic [1:0] c_st_serve = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [NFLOORS-1:0] r_pending;
    logic [NFLOORS-1:0] w_pending_nxt;
    logic [FW-1:0]      r_req_floor;
    logic [FW-1:0]      w_req_floor_nxt;
    logic               r_req_valid;
    logic               r_dir_up;
    logic               w_dir_up_nxt;

    logic               w_here;
    logic               w_up_found;
    logic [FW-1:0]      w_up_floor;
    logic               w_dn_found;
    logic [FW-1:0]      w_dn_floor;
    logic               w_tgt_found;
    logic [FW-1:0]      w_tgt_floor;
    logic               w_tgt_flip;

    // Pending update: a door opening at a floor retires it, even if called again.
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            w_pending_nxt[i] = (r_pending[i] | call_btn[i])
                             & ~(door_open && (cur_floor == FW'(i)));
        end
    end

    // Pending request bitmap register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Nearest pending floor above and below the car; an out-of-range
    // cur_floor simply has nothing above it.
    always_comb begin
        w_here     = 1'b0;
        w_up_found = 1'b0;
        w_up_floor = '0;
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (r_pending[i] && (FW'(i) == cur_floor)) begin
                w_here = 1'b1;
            end
        end
        // Descending scan so the lowest floor above the car wins.
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (FW'(i) > cur_floor)) begin
                w_up_found = 1'b1;
                w_up_floor = FW'(i);
            end
        end
        // Ascending scan so the highest floor below the car wins.
        for (int i = 0; i < NFLOORS; i++) begin
            if (r_pending[i] && (FW'(i) < cur_floor)) begin
                w_dn_found = 1'b1;
                w_dn_floor = FW'(i);
            end
        end
    end

    // SCAN priority: current floor, then ahead, then behind (reversal).
    always_comb begin
        w_tgt_found = 1'b0;
        w_tgt_floor = '0;
        w_tgt_flip  = 1'b0;
        if (w_here) begin
            w_tgt_found = 1'b1;
            w_tgt_floor = cur_floor;
        end else if (r_dir_up) begin
            if (w_up_found) begin
                w_tgt_found = 1'b1;
                w_tgt_floor = w_up_floor;
            end else if (w_dn_found) begin
                w_tgt_found = 1'b1;
                w_tgt_floor = w_dn_floor;
                w_tgt_flip  = 1'b1;
            end
        end else begin
            if (w_dn_found) begin
                w_tgt_found = 1'b1;
                w_tgt_floor = w_dn_floor;
            end else if (w_up_found) begin
                w_tgt_found = 1'b1;
                w_tgt_floor = w_up_floor;
                w_tgt_flip  = 1'b1;
            end
        end
    end

    // Next-state logic: target latch in IDLE, en-route pickup in MOVE.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_floor_nxt = r_req_floor;
        w_dir_up_nxt    = r_dir_up;
        case (r_state)
            c_st_idle: begin
                if (w_tgt_found) begin
                    w_state_nxt     = c_st_move;
                    w_req_floor_nxt = w_tgt_floor;
                    w_dir_up_nxt    = r_dir_up ^ w_tgt_flip;
                end
            end
            c_st_move: begin
                if (door_open && (cur_floor == r_req_floor)) begin
                    w_state_nxt = c_st_serve;
                end else if (r_dir_up && w_up_found && (w_up_floor < r_req_floor)) begin
                    w_req_floor_nxt = w_up_floor;
                end else if (!r_dir_up && w_dn_found && (w_dn_floor > r_req_floor)) begin
                    w_req_floor_nxt = w_dn_floor;
                end
            end
            c_st_serve: begin
                if (!door_open) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State, target and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_req_floor <= '0;
            r_req_valid <= 1'b0;
            r_dir_up    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_req_floor <= w_req_floor_nxt;
            r_req_valid <= (w_state_nxt != c_st_idle);
            r_dir_up    <= w_dir_up_nxt;
        end
    end

    assign req_floor = r_req_floor;
    assign req_valid = r_req_valid;
    assign dir_up    = r_dir_up;
    assign pending   = r_pending;
    assign busy      = (r_state != c_st_idle) || (|r_pending);

endmodule
`default_nettype wire

// File: doc/lift_req_scheduler.md
Name: lift_req_scheduler

Overview:
- Collects floor call requests from all floors and holds them as pending requests.
- Uses a SCAN (elevator) policy to choose which floor the lift car serves next.
- Drives the target-floor input of the single-car lift FSM and tracks its direction.
- Watches the lift's floor and door status to retire each request once it is served.

Parameters:
- NFLOORS, 5, number of floors served (floor 0 = ground); legal range 2..8.
- FW, 3, floor index width; must satisfy 2**FW >= NFLOORS.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- call_btn, input, NFLOORS, one bit per floor; any cycle a bit is high latches that floor's request (pulse or level).
- cur_floor, input, FW, current floor reported by the lift FSM.
- door_open, input, 1, high while the lift holds its door open at cur_floor.
- req_floor, output reg, FW, target floor presented to the lift FSM.
- req_valid, output reg, 1, high while req_floor is a live target.
- dir_up, output reg, 1, scan direction: 1 = up, 0 = down.
- pending, output reg, NFLOORS, outstanding request bitmap.
- busy, output, 1, high when state is not IDLE or pending is nonzero.

Behaviour:
- Reset values: state=IDLE, pending=0, req_floor=0, req_valid=0, dir_up=1, busy=0. Reset mid-operation drops all pending requests and the current target.
- Pending register, per floor i, each cycle:
  - set if call_btn[i];
  - clear if door_open && cur_floor==i;
  - clear wins over set when both happen in the same cycle, because the floor is being served.
  - cur_floor >= NFLOORS clears nothing.
- Target selection, combinational, from pending and cur_floor:
  - Priority 1: pending[cur_floor] -> target cur_floor.
  - Priority 2: otherwise, the nearest pending floor in the dir_up direction. Going up, this is the lowest pending floor above cur_floor. Going down, it is the highest pending floor below cur_floor.
  - Priority 3: otherwise, the nearest pending floor in the opposite direction, and dir_up toggles when that target is latched.
  - "None" when pending==0.
- State machine:
  - IDLE: req_valid=0. If a target exists, latch req_floor, update dir_up, set req_valid=1, and go to MOVE. Latency: call_btn at cycle t -> pending at t+1 -> req_valid/req_floor registered at t+2.
  - MOVE: req_valid=1.
    - En-route pickup: if a pending floor lies strictly between cur_floor and req_floor in the dir_up direction, req_floor is updated to the pending floor nearest cur_floor. Direction is unchanged.
    - If door_open && cur_floor==req_floor, go to SERVE.
  - SERVE: req_valid stays 1 and req_floor is held. When door_open falls, go to IDLE. A call for this floor that arrives while the door is open is absorbed; it is not re-latched.
- req_floor never changes while in SERVE. dir_up only changes in IDLE.
- A MOVE whose target arrives with door_open on the first cycle still passes through SERVE for at least 1 cycle.
- Arithmetic: floor comparisons are unsigned FW-bit. Bitmap bits >= NFLOORS do not exist. Upward searches never wrap past NFLOORS-1, and downward searches never wrap below 0.

Test Plan:
- Reset then idle: rst for 2 cycles, no calls -> pending=0, req_valid=0, dir_up=1, busy=0 throughout.
- Single call: cur_floor=0, pulse call_btn[3] at t -> pending=01000 at t+1; req_floor=3, req_valid=1, dir_up=1 at t+2. Drive cur_floor=3 with door_open for 4 cycles -> pending[3]=0, SERVE, then IDLE with req_valid=0 one cycle after door_open falls.
- En-route pickup: target 4 latched from cur_floor 0, then call_btn[2] while cur_floor=1 -> req_floor changes to 2. After floor 2 is served -> next target 4.
- Scan order and reversal: cur_floor=2, dir_up=1, pending={0,3,4} -> serves 3, then 4, then 0, with dir_up=0 when 0 is latched.
- Same-floor and clear-wins: cur_floor=1, door_open=1, call_btn[1] asserted in the same cycle -> pending[1] stays 0. With door closed, call_btn[1] -> req_floor=1 latched.
- Reset mid-move: in MOVE with pending=10110, assert rst -> next cycle all outputs at reset values.
